miriscv_lsu: RTL and testbench

Load/store unit for the MIRISCV core: accepts one load or store per instruction from the execute stage and initiates it on the core's data memory interface. The testbench memory agent is the responder on the other end. The unit formats store data and byte enables, stalls the pipeline until the memory answers with `data_rvalid_i`, then aligns and sign- or zero-extends load data back to the pipeline.

---
 rtl/miriscv_lsu.sv | 170 +++++++++++++++++
 tb/tb_miriscv_lsu.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_lsu.sv
// MIRISCV load/store unit: one memory access per request, stalls the pipeline until data_rvalid_i.
// MIRISCV_LSU_MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and pulse lsu_misalign_o.
module miriscv_lsu (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_size_i,
  input  logic        lsu_uns_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        lsu_kill_i,
  output logic        lsu_stall_o,
  output logic        lsu_done_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_misalign_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic        killed_q, killed_d;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic        data_req_q, data_we_q;
  logic [3:0]  data_be_q;
  logic [31:0] data_addr_q, data_wdata_q;
  logic        done_q, misalign_q;
  logic [31:0] rdata_q;

  logic        accept, load_upd, trap;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, shifted_c, ext_c;

`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
  assign trap = (lsu_size_i == 2'b01) ? lsu_addr_i[0] :
                (lsu_size_i[1] ? (|lsu_addr_i[1:0]) : 1'b0);
`else
  assign trap = 1'b0;
`endif

  // Store formatting replicates the operand into every lane so the enables pick the right one.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = lsu_wdata_i;
    case (lsu_size_i)
      2'b00: begin
        be_c    = 4'b0001 << lsu_addr_i[1:0];
        wdata_c = {4{lsu_wdata_i[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << {lsu_addr_i[1], 1'b0};
        wdata_c = {2{lsu_wdata_i[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = lsu_wdata_i;
      end
    endcase
  end

  always_comb begin
    shifted_c = data_rdata_i;
    ext_c     = data_rdata_i;
    case (size_q)
      2'b00: begin
        shifted_c = data_rdata_i >> {off_q, 3'b000};
        ext_c     = {{24{~uns_q & shifted_c[7]}}, shifted_c[7:0]};
      end
      2'b01: begin
        shifted_c = data_rdata_i >> {off_q[1], 4'b0000};
        ext_c     = {{16{~uns_q & shifted_c[15]}}, shifted_c[15:0]};
      end
      default: begin
        shifted_c = data_rdata_i;
        ext_c     = data_rdata_i;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    killed_d    = killed_q;
    accept      = 1'b0;
    load_upd    = 1'b0;
    lsu_stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        lsu_stall_o = lsu_req_i;
        if (lsu_req_i && !lsu_kill_i) begin
          accept  = 1'b1;
          state_d = trap ? DONE : REQ;
        end
      end
      REQ: begin
        lsu_stall_o = 1'b1;
        state_d     = WAIT;
        if (lsu_kill_i) killed_d = 1'b1;
      end
      WAIT: begin
        lsu_stall_o = 1'b1;
        if (lsu_kill_i) killed_d = 1'b1;
        // A flushed access still drains its bus response, but never reports completion.
        if (data_rvalid_i) begin
          killed_d = 1'b0;
          if (killed_q || lsu_kill_i) begin
            state_d = IDLE;
          end else begin
            state_d  = DONE;
            load_upd = !data_we_q;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q      <= IDLE;
      killed_q     <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      data_req_q   <= 1'b0;
      data_we_q    <= 1'b0;
      data_be_q    <= 4'b0000;
      data_addr_q  <= 32'd0;
      data_wdata_q <= 32'd0;
      done_q       <= 1'b0;
      misalign_q   <= 1'b0;
      rdata_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      killed_q   <= killed_d;
      data_req_q <= accept && !trap;
      done_q     <= (state_d == DONE);
      misalign_q <= accept && trap;
      if (accept) begin
        size_q       <= lsu_size_i;
        uns_q        <= lsu_uns_i;
        off_q        <= lsu_addr_i[1:0];
        data_we_q    <= lsu_we_i;
        data_be_q    <= be_c;
        data_addr_q  <= {lsu_addr_i[31:2], 2'b00};
        data_wdata_q <= wdata_c;
      end
      if (load_upd) rdata_q <= ext_c;
    end
  end

  assign lsu_done_o     = done_q;
  assign lsu_rdata_o    = rdata_q;
  assign lsu_misalign_o = misalign_q;
  assign data_req_o     = data_req_q;
  assign data_we_o      = data_we_q;
  assign data_be_o      = data_be_q;
  assign data_addr_o    = data_addr_q;
  assign data_wdata_o   = data_wdata_q;

endmodule

// File: tb/tb_miriscv_lsu.sv
// Randomized self-checking bench for miriscv_lsu with a byte-lane arithmetic reference model.
module tb_miriscv_lsu;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        lsu_req_i, lsu_we_i, lsu_uns_i, lsu_kill_i;
  logic [1:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_stall_o, lsu_done_o, lsu_misalign_o;
  logic [31:0] lsu_rdata_o;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  miriscv_lsu dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_uns_i(lsu_uns_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_kill_i(lsu_kill_i), .lsu_stall_o(lsu_stall_o), .lsu_done_o(lsu_done_o),
    .lsu_rdata_o(lsu_rdata_o), .lsu_misalign_o(lsu_misalign_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_last = 32'd0;

  int          obs_req_cyc, obs_req_cnt, obs_done_cyc, obs_done_cnt, obs_drop, obs_rv;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata, obs_rdata, obs_rdata_end;
  logic        obs_we, obs_mis;

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
  endfunction

  function automatic int lane_off(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    return ((int'(a % 4)) / n) * n;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    int v = ((1 << n) - 1) << lane_off(sz, a);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    int n = nbytes(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a, input logic [31:0] mem);
    int n = nbytes(sz);
    longint lim = longint'(1) << (8 * n);
    longint v = (longint'({32'd0, mem}) >> (8 * lane_off(sz, a))) % lim;
    logic [63:0] r;
    if (!uns && n < 4 && v >= lim / 2) v = v - lim;
    r = v;
    return r[31:0];
  endfunction

  function automatic bit m_trap(input logic [1:0] sz, input logic [31:0] a);
`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
    return (nbytes(sz) > 1) && ((a % nbytes(sz)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- driver + memory responder (records observations only) ----------------
  task automatic do_access(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mem,
                           input int waits, input int kill_cyc);
    int rv_cyc = -1;
    bit released = 1'b0;
    obs_req_cyc = -1; obs_req_cnt = 0; obs_done_cyc = -1; obs_done_cnt = 0;
    obs_drop = -1; obs_rv = -1; obs_be = 4'h0; obs_addr = '0; obs_wdata = '0;
    obs_we = 1'b0; obs_rdata = '0; obs_mis = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (c == kill_cyc) released = 1'b1;
      lsu_req_i     = !released;
      lsu_we_i      = we;
      lsu_size_i    = sz;
      lsu_uns_i     = uns;
      lsu_addr_i    = a;
      lsu_wdata_i   = wd;
      lsu_kill_i    = (c == kill_cyc);
      data_rvalid_i = (c == rv_cyc);
      data_rdata_i  = (c == rv_cyc) ? mem : $urandom;
      #1;
      if (data_req_o) begin
        obs_req_cnt++;
        if (obs_req_cyc < 0) begin
          obs_req_cyc = c; obs_be = data_be_o; obs_addr = data_addr_o;
          obs_wdata = data_wdata_o; obs_we = data_we_o;
          rv_cyc = c + 1 + waits; obs_rv = rv_cyc;
        end
      end
      if (lsu_done_o) begin
        obs_done_cnt++;
        if (obs_done_cyc < 0) begin
          obs_done_cyc = c; obs_rdata = lsu_rdata_o; obs_mis = lsu_misalign_o;
        end
      end
      if (!lsu_stall_o && obs_drop < 0) begin
        obs_drop = c; released = 1'b1;
      end
      if (obs_drop >= 0 && c == obs_drop + 1) break;
    end
    obs_rdata_end = lsu_rdata_o;
    lsu_req_i = 1'b0; lsu_kill_i = 1'b0; data_rvalid_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_size_i = 2'b10; lsu_addr_i = 32'h40;
    #1;
    total++; if (lsu_stall_o !== 1'b1) begin bad++; $display("FAIL rst_stall_req got=%b exp=1", lsu_stall_o); end
    @(negedge clk_i); @(negedge clk_i); #1;
    total++; if (data_req_o !== 1'b0) begin bad++; $display("FAIL rst_no_accept got=%b exp=0", data_req_o); end
    total++; if ({lsu_done_o, lsu_misalign_o, data_we_o, data_be_o} !== 7'd0) begin bad++;
      $display("FAIL rst_ctrl got=%b exp=0", {lsu_done_o, lsu_misalign_o, data_we_o, data_be_o}); end
    total++; if ({lsu_rdata_o, data_addr_o, data_wdata_o} !== 96'd0) begin bad++;
      $display("FAIL rst_data got=%h exp=0", {lsu_rdata_o, data_addr_o, data_wdata_o}); end
    lsu_req_i = 1'b0;
    #1;
    total++; if (lsu_stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall_idle got=%b exp=0", lsu_stall_o); end
    @(negedge clk_i);
    arst_i = 1'b0;
  endtask

  task automatic test_word_load;
    do_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, -1);
    total++; if (obs_req_cyc !== 1) begin bad++; $display("FAIL wl_req_cyc got=%0d exp=1", obs_req_cyc); end
    total++; if (obs_addr !== 32'h100 || obs_be !== 4'hF || obs_we !== 1'b0) begin bad++;
      $display("FAIL wl_bus got=%h/%b/%b exp=00000100/1111/0", obs_addr, obs_be, obs_we); end
    total++; if (obs_done_cyc !== 3 || obs_done_cnt !== 1) begin bad++;
      $display("FAIL wl_done got=%0d/%0d exp=3/1", obs_done_cyc, obs_done_cnt); end
    total++; if (obs_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wl_rdata got=%h exp=deadbeef", obs_rdata); end
    total++; if (obs_drop !== 3 || obs_req_cnt !== 1) begin bad++;
      $display("FAIL wl_stall got=%0d/%0d exp=3/1", obs_drop, obs_req_cnt); end
    exp_last = 32'hDEADBEEF;
  endtask

  task automatic test_byte_load;
    do_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80123456, 0, -1);
    total++; if (obs_be !== 4'b1000) begin bad++; $display("FAIL lb_be got=%b exp=1000", obs_be); end
    total++; if (obs_rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_rdata got=%h exp=ffffff80", obs_rdata); end
    do_access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80123456, 0, -1);
    total++; if (obs_rdata !== 32'h00000080) begin bad++; $display("FAIL lbu_rdata got=%h exp=00000080", obs_rdata); end
    exp_last = 32'h00000080;
  endtask

  task automatic test_half_store;
    do_access(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 32'h0, 1, -1);
    total++; if (obs_addr !== 32'h200 || obs_be !== 4'b1100) begin bad++;
      $display("FAIL sh_bus got=%h/%b exp=00000200/1100", obs_addr, obs_be); end
    total++; if (obs_wdata !== 32'hABCDABCD || obs_we !== 1'b1) begin bad++;
      $display("FAIL sh_wdata got=%h/%b exp=abcdabcd/1", obs_wdata, obs_we); end
    total++; if (obs_done_cyc !== obs_rv + 1 || obs_done_cyc !== 4) begin bad++;
      $display("FAIL sh_done got=%0d exp=4", obs_done_cyc); end
    total++; if (obs_rdata_end !== exp_last) begin bad++; $display("FAIL sh_rdata_keep got=%h exp=%h", obs_rdata_end, exp_last); end
  endtask

  task automatic test_kill;
    do_access(1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 32'h12345678, 3, 3);
    total++; if (obs_req_cnt !== 1) begin bad++; $display("FAIL kill_req got=%0d exp=1", obs_req_cnt); end
    total++; if (obs_done_cnt !== 0) begin bad++; $display("FAIL kill_done got=%0d exp=0", obs_done_cnt); end
    total++; if (obs_drop !== 6) begin bad++; $display("FAIL kill_stall got=%0d exp=6", obs_drop); end
    total++; if (obs_rdata_end !== exp_last) begin bad++; $display("FAIL kill_rdata got=%h exp=%h", obs_rdata_end, exp_last); end
  endtask

  task automatic test_misalign;
    logic [31:0] mem = $urandom;
    do_access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, mem, 0, -1);
`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
    total++; if (obs_req_cnt !== 0) begin bad++; $display("FAIL mis_req got=%0d exp=0", obs_req_cnt); end
    total++; if (obs_done_cyc !== 1 || obs_mis !== 1'b1) begin bad++;
      $display("FAIL mis_done got=%0d/%b exp=1/1", obs_done_cyc, obs_mis); end
    total++; if (obs_rdata_end !== exp_last) begin bad++; $display("FAIL mis_rdata got=%h exp=%h", obs_rdata_end, exp_last); end
`else
    total++; if (obs_addr !== 32'h100 || obs_be !== 4'hF) begin bad++;
      $display("FAIL mis_bus got=%h/%b exp=00000100/1111", obs_addr, obs_be); end
    total++; if (obs_mis !== 1'b0 || obs_done_cyc !== 3) begin bad++;
      $display("FAIL mis_done got=%b/%0d exp=0/3", obs_mis, obs_done_cyc); end
    total++; if (obs_rdata !== mem) begin bad++; $display("FAIL mis_rdata got=%h exp=%h", obs_rdata, mem); end
    exp_last = mem;
`endif
  endtask

  task automatic test_reset_mid;
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 2'b10; lsu_uns_i = 1'b0;
    lsu_addr_i = 32'h300; lsu_kill_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1 arst_i = 1'b1;
    #1;
    total++; if ({data_req_o, lsu_done_o, lsu_misalign_o, data_we_o, data_be_o} !== 8'd0) begin bad++;
      $display("FAIL rmid_ctrl got=%b exp=0", {data_req_o, lsu_done_o, lsu_misalign_o, data_we_o, data_be_o}); end
    total++; if ({lsu_rdata_o, data_addr_o, data_wdata_o} !== 96'd0) begin bad++;
      $display("FAIL rmid_data got=%h exp=0", {lsu_rdata_o, data_addr_o, data_wdata_o}); end
    lsu_req_i = 1'b0;
    @(negedge clk_i);
    arst_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFEF00D;
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    #1;
    total++; if (lsu_done_o !== 1'b0 || lsu_rdata_o !== 32'd0 || lsu_stall_o !== 1'b0) begin bad++;
      $display("FAIL rmid_late_rvalid got=%b/%h/%b exp=0/0/0", lsu_done_o, lsu_rdata_o, lsu_stall_o); end
    exp_last = 32'd0;
    do_access(1'b0, 2'b01, 1'b0, 32'h306, 32'h0, 32'h9ABC1234, 0, -1);
    total++; if (obs_done_cyc !== 3 || obs_rdata !== 32'hFFFF9ABC) begin bad++;
      $display("FAIL rmid_next got=%0d/%h exp=3/ffff9abc", obs_done_cyc, obs_rdata); end
    exp_last = 32'hFFFF9ABC;
  endtask

  task automatic test_random;
    for (int k = 0; k < 30; k++) begin
      logic        we = $urandom_range(0, 1);
      logic [1:0]  sz = $urandom_range(0, 3);
      logic        uns = $urandom_range(0, 1);
      logic [31:0] a = $urandom;
      logic [31:0] wd = $urandom;
      logic [31:0] mem = $urandom;
      int          w = $urandom_range(0, 3);
      do_access(we, sz, uns, a, wd, mem, w, -1);
      if (m_trap(sz, a)) begin
        total++; if (obs_req_cnt !== 0 || obs_done_cyc !== 1 || obs_mis !== 1'b1) begin bad++;
          $display("FAIL rnd_trap k=%0d got=%0d/%0d/%b exp=0/1/1", k, obs_req_cnt, obs_done_cyc, obs_mis); end
        total++; if (obs_rdata_end !== exp_last) begin bad++;
          $display("FAIL rnd_trap_rdata k=%0d got=%h exp=%h", k, obs_rdata_end, exp_last); end
      end else begin
        total++; if (obs_req_cyc !== 1 || obs_req_cnt !== 1 || obs_addr !== {a[31:2], 2'b00}) begin bad++;
          $display("FAIL rnd_req k=%0d got=%0d/%0d/%h exp=1/1/%h", k, obs_req_cyc, obs_req_cnt, obs_addr, {a[31:2], 2'b00}); end
        total++; if (obs_be !== m_be(sz, a) || obs_we !== we) begin bad++;
          $display("FAIL rnd_be k=%0d got=%b/%b exp=%b/%b", k, obs_be, obs_we, m_be(sz, a), we); end
        if (we) begin
          total++; if (obs_wdata !== m_wdata(sz, wd)) begin bad++;
            $display("FAIL rnd_wdata k=%0d got=%h exp=%h", k, obs_wdata, m_wdata(sz, wd)); end
        end else begin
          exp_last = m_load(sz, uns, a, mem);
        end
        total++; if (obs_done_cyc !== 3 + w || obs_done_cnt !== 1 || obs_mis !== 1'b0) begin bad++;
          $display("FAIL rnd_done k=%0d got=%0d/%0d/%b exp=%0d/1/0", k, obs_done_cyc, obs_done_cnt, obs_mis, 3 + w); end
        total++; if (obs_rdata !== exp_last) begin bad++;
          $display("FAIL rnd_rdata k=%0d got=%h exp=%h", k, obs_rdata, exp_last); end
      end
    end
  endtask

  task automatic test_back_to_back;
    int rvp = -1;
    int nreq = 0;
    int ndone = 0;
    int rc[4];
    int dc[4];
    logic [31:0] ra[4];
    logic [31:0] dr[4];
    for (int c = 0; c < 11; c++) begin
      @(negedge clk_i);
      lsu_req_i = (c < 8); lsu_we_i = 1'b0; lsu_size_i = 2'b10; lsu_uns_i = 1'b0; lsu_kill_i = 1'b0;
      lsu_addr_i = (c < 4) ? 32'h400 : 32'h404;
      data_rvalid_i = (c == rvp);
      data_rdata_i = (c < 4) ? 32'h11112222 : 32'h33334444;
      #1;
      if (data_req_o) begin
        if (nreq < 4) begin rc[nreq] = c; ra[nreq] = data_addr_o; end
        nreq++; rvp = c + 1;
      end
      if (lsu_done_o) begin
        if (ndone < 4) begin dc[ndone] = c; dr[ndone] = lsu_rdata_o; end
        ndone++;
      end
    end
    lsu_req_i = 1'b0; data_rvalid_i = 1'b0;
    total++; if (nreq !== 2 || ndone !== 2) begin bad++; $display("FAIL b2b_count got=%0d/%0d exp=2/2", nreq, ndone); end
    else begin
      total++; if (rc[0] !== 1 || rc[1] !== 5) begin bad++; $display("FAIL b2b_req_cyc got=%0d/%0d exp=1/5", rc[0], rc[1]); end
      total++; if (ra[0] !== 32'h400 || ra[1] !== 32'h404) begin bad++; $display("FAIL b2b_addr got=%h/%h exp=400/404", ra[0], ra[1]); end
      total++; if (dc[0] !== 3 || dc[1] !== 7) begin bad++; $display("FAIL b2b_done_cyc got=%0d/%0d exp=3/7", dc[0], dc[1]); end
      total++; if (dr[0] !== 32'h11112222 || dr[1] !== 32'h33334444) begin bad++;
        $display("FAIL b2b_rdata got=%h/%h exp=11112222/33334444", dr[0], dr[1]); end
    end
    exp_last = 32'h33334444;
  endtask

  initial begin
    arst_i = 1'b1;
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'b00; lsu_uns_i = 1'b0;
    lsu_addr_i = '0; lsu_wdata_i = '0; lsu_kill_i = 1'b0;
    data_rvalid_i = 1'b0; data_rdata_i = '0;
    test_reset;
    test_word_load;
    test_byte_load;
    test_half_store;
    test_kill;
    test_misalign;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
